fb_program_ram: RTL and testbench
=================================

# fb_program_ram

Memory-side responder for the FBCPU memory bus: a single-port 2^ADDRESS_WIDTH × DATA_WIDTH synchronous RAM that answers the CPU's MAR/RAMWr/MDRIn requests with MDROut. It also provides a program-load port that fills RAM from address 0 over a valid/ready stream. While clearing or loading, the block holds the CPU in reset through `cpu_rst`. It sits beside FBCPU at the top level, which also feeds the CPU's `PC` to debug.

## Interface
- ADDRESS_WIDTH, 6, RAM address width; depth = 2^ADDRESS_WIDTH
- DATA_WIDTH, 10, word width
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- MAR  in  ADDRESS_WIDTH  CPU address
- RAMWr  in  1  CPU write strobe
- MDRIn  in  DATA_WIDTH  CPU write data
- MDROut  out  DATA_WIDTH  registered read data to CPU
- cpu_rst  out  1  reset to FBCPU; high during CLEAR and LOAD
- load_start  in  1  single-cycle request to begin a program load
- load_valid  in  1  load word present
- load_data  in  DATA_WIDTH  load word
- load_last  in  1  marks final word, qualified by load_valid
- load_ready  out  1  block accepts a load word this cycle
- load_done  out  1  one-cycle pulse when a load completes
- load_count  out  ADDRESS_WIDTH+1  words written by the last or current load

## Operation
- The state machine has three states: CLEAR, RUN and LOAD. `rst` forces CLEAR from any state, including mid-load.
- **CLEAR**
  - An address counter walks 0 → 2^AW−1 and writes 0 each cycle, taking 2^AW cycles.
  - The cycle after address 2^AW−1 is written, the state becomes RUN.
  - `load_start` is ignored during CLEAR.
- **RUN**
  - CPU port is active. RAMWr=1 writes MDRIn to mem[MAR] at the clock edge.
  - Each cycle, MDROut is registered as mem[MAR]. A write and a read to the same address in one cycle return the old data.
  - `load_start` moves the state to LOAD and clears the address counter and `load_count` to 0.
- **LOAD**
  - `load_ready`=1. When load_valid && load_ready, the block writes load_data to mem[counter] and increments both the counter and `load_count`.
  - The load ends when the accepted word has load_last=1, or when the accepted word is at address 2^AW−1 (no wrap). On that transfer `load_done` pulses the next cycle and the state becomes RUN.
  - Words not written during a load keep their previous contents.
  - `load_start` during LOAD is ignored.
- **CPU port outside RUN**: in CLEAR and LOAD, CPU RAMWr is ignored and MDROut is forced to 0.
- **Width rules**: the address counter is ADDRESS_WIDTH bits. `load_count` is one bit wider so a full load reads 2^AW (64).

## Timing
- **Reset values**: MDROut=0, cpu_rst=1, load_ready=0, load_done=0, load_count=0, state=CLEAR.
- **Read latency** is 1 cycle: MAR presented in cycle N gives MDROut valid in cycle N+1. This matches the CPU's present-address / capture-data state pair.
- **Write** takes effect at the edge ending the cycle in which RAMWr is high. A read of that address in the next cycle sees the new data.
- **cpu_rst**
  - Registered: high in the cycle the state enters CLEAR or LOAD.
  - Falls the cycle after the state reaches RUN. The CPU therefore starts its fetch at PC=0 one cycle after `load_done`.
- **load_ready**: registered, high from the cycle after `load_start` until the final transfer cycle inclusive, then low.
- **Fixed costs**
  - Post-reset clear: 2^AW cycles plus 1 before cpu_rst drops.
  - Loading n words with no stalls: n cycles.

## Structure
- **Shared package** `fb_pkg`:
  - state enum {CLEAR, RUN, LOAD}
  - localparams FB_ADDRESS_WIDTH=6, FB_DATA_WIDTH=10
  - opcode constants, shared with FBCPU
- **Sub-module** `fb_ram_array`: a plain single-port synchronous RAM with registered read and write-first-ignored semantics (old data on same-address read/write).
- **Top of this block** owns:
  - the FSM
  - the address counter
  - the write-port mux: the zero source in CLEAR, load_data in LOAD, MDRIn in RUN
  - the MDROut gating

## Test plan
- **Reset clear**: reset, then run 65 cycles → cpu_rst high for cycles 0–64. Afterwards a RUN read of every address returns 0.
- **Load 3 words**: load_start, then 0x181, 0x0C2, 0x200 (last) on consecutive cycles.
  - Required: load_done pulses once, load_count=3, cpu_rst low the next cycle.
  - Reads of MAR=0,1,2 return 0x181, 0x0C2, 0x200, each 1 cycle after MAR.
- **Stalled load**: toggle load_valid 1/0 over 4 words → only valid cycles write, and the addresses are contiguous 0–3.
- **Full load**: 64 words without load_last → ends after address 63 with load_count=64 and no wrap. Address 0 keeps word 0.
- **CPU write/read**: MAR=5, RAMWr=1, MDRIn=0x3FF, then MAR=5 read → MDROut=0x3FF. A same-cycle read during the write returns the old value.
- **Reset mid-load**: rst asserted after 2 load words → state CLEAR, load_ready=0, cpu_rst=1, no load_done, and memory is zeroed afterwards.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared FBCPU definitions: memory geometry, block state encoding and the
// instruction opcodes the CPU decodes out of words held in program RAM.
package fb_pkg;

  localparam int FB_ADDRESS_WIDTH = 6;
  localparam int FB_DATA_WIDTH    = 10;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } fb_state_e;

  // Upper 4 bits of a 10-bit instruction word; the low 6 bits carry an address.
  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;

endpackage

// File: rtl/fb_program_ram_if.sv
// CPU memory bus plus program-load stream between FBCPU/loader and program RAM.
interface fb_program_ram_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  logic [ADDRESS_WIDTH-1:0] MAR;
  logic                     RAMWr;
  logic [DATA_WIDTH-1:0]    MDRIn;
  logic [DATA_WIDTH-1:0]    MDROut;
  logic                     load_start;
  logic                     load_valid;
  logic [DATA_WIDTH-1:0]    load_data;
  logic                     load_last;
  logic                     load_ready;
  logic                     load_done;
  logic [ADDRESS_WIDTH:0]   load_count;

  modport master (
    output MAR, RAMWr, MDRIn, load_start, load_valid, load_data, load_last,
    input  MDROut, load_ready, load_done, load_count
  );

  modport slave (
    input  MAR, RAMWr, MDRIn, load_start, load_valid, load_data, load_last,
    output MDROut, load_ready, load_done, load_count
  );
endinterface

// File: rtl/fb_ram_array.sv
// Single-port synchronous RAM; a same-address read during a write returns old data.
module fb_ram_array #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fb_program_ram.sv
// FBCPU program RAM: zero-fill after reset, stream program load, then serve the CPU bus.
module fb_program_ram
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  fb_program_ram_if.slave   bus,
  output logic              cpu_rst
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  fb_state_e                state;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH:0]   load_count;
  logic                     load_ready;
  logic                     load_done;
  logic                     rd_ok;

  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  logic load_xfer, load_end;

  assign load_xfer = (state == LOAD) && load_ready && bus.load_valid;
  // No wrap: a word accepted at the top address always terminates the load.
  assign load_end  = load_xfer && (bus.load_last || cnt == LAST_ADDR);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = bus.MAR;
    ram_wdata = bus.MDRIn;
    unique case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = '0;
      end
      LOAD: begin
        ram_we    = load_xfer;
        ram_addr  = cnt;
        ram_wdata = bus.load_data;
      end
      default: ram_we = bus.RAMWr;
    endcase
    if (rst) ram_we = 1'b0;
  end

  fb_ram_array #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      load_count <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      cpu_rst    <= 1'b1;
      rd_ok      <= 1'b0;
    end else begin
      load_done <= 1'b0;
      rd_ok     <= (state == RUN);
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= RUN;
        end
        RUN: begin
          cpu_rst <= 1'b0;
          if (bus.load_start) begin
            state      <= LOAD;
            cnt        <= '0;
            load_count <= '0;
            load_ready <= 1'b1;
            cpu_rst    <= 1'b1;
          end
        end
        LOAD: begin
          if (load_xfer) begin
            cnt        <= cnt + 1'b1;
            load_count <= load_count + 1'b1;
          end
          if (load_end) begin
            state      <= RUN;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Read data is only meaningful if it was addressed in RUN and we are still in RUN.
  assign bus.MDROut     = (rd_ok && state == RUN) ? ram_rdata : '0;
  assign bus.load_ready = load_ready;
  assign bus.load_done  = load_done;
  assign bus.load_count = load_count;

endmodule

// File: tb/tb_fb_program_ram.sv
// Directed bench for fb_program_ram: clear, loads, CPU access, reset mid-load.
module tb_fb_program_ram;

  logic clk = 1'b0;
  logic rst;
  logic cpu_rst;

  int checks   = 0;
  int failures = 0;

  logic [9:0] words [64];

  fb_program_ram_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) bus ();

  fb_program_ram dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [9:0] exp, input string tag);
    bus.MAR   = addr;
    bus.RAMWr = 1'b0;
    tick();
    check(tag, bus.MDROut, exp);
  endtask

  // Waits for cpu_rst to fall after a reset pulse; clear must take exactly 65 cycles.
  task automatic clear_wait(input string tag);
    int n     = 0;
    int dones = 0;
    while (cpu_rst === 1'b1 && n < 100) begin
      tick();
      n++;
      dones += int'(bus.load_done);
    end
    check({tag, "_cycles"}, n, 65);
    check({tag, "_no_done"}, dones, 0);
  endtask

  task automatic do_load(input int n, input bit use_last, input bit stall);
    int dones = 0;
    bus.MAR        = 6'd0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("ld_ready_rise", bus.load_ready, 1);
    check("ld_cpu_rst_hi", cpu_rst, 1);
    check("ld_count_clr", bus.load_count, 0);
    check("ld_mdr_gated", bus.MDROut, 0);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        // idle cycle; a stray load_start here must not restart the load
        bus.load_valid = 1'b0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        dones += int'(bus.load_done);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = use_last && (i == n - 1);
      tick();
      if (i < n - 1) dones += int'(bus.load_done);
    end
    // keep offering a word: it must be ignored once the load has ended
    bus.load_last = 1'b0;
    bus.load_data = 10'h3AA;
    check("ld_done", bus.load_done, 1);
    check("ld_count", bus.load_count, n);
    check("ld_ready_fall", bus.load_ready, 0);
    check("ld_no_early_done", dones, 0);
    check("ld_cpu_rst_still_hi", cpu_rst, 1);
    tick();
    bus.load_valid = 1'b0;
    check("ld_done_one_cycle", bus.load_done, 0);
    check("ld_cpu_rst_fall", cpu_rst, 0);
    check("ld_count_hold", bus.load_count, n);
  endtask

  initial begin
    rst            = 1'b1;
    bus.MAR        = '0;
    bus.RAMWr      = 1'b0;
    bus.MDRIn      = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_mdrout", bus.MDROut, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_load_count", bus.load_count, 0);

    rst = 1'b0;
    clear_wait("clr");
    for (int a = 0; a < 64; a++) rd(6'(a), 10'h000, "clr_zero");

    // stalled load: valid toggles, addresses must stay contiguous 0..3
    words[0] = 10'h011; words[1] = 10'h022; words[2] = 10'h033; words[3] = 10'h044;
    do_load(4, 1'b1, 1'b1);
    rd(6'd0, 10'h011, "stl_a0");
    rd(6'd1, 10'h022, "stl_a1");
    rd(6'd2, 10'h033, "stl_a2");
    rd(6'd3, 10'h044, "stl_a3");
    rd(6'd4, 10'h000, "stl_a4");

    // three-word load; address 3 keeps the stalled-load word
    words[0] = 10'h181; words[1] = 10'h0C2; words[2] = 10'h200;
    do_load(3, 1'b1, 1'b0);
    rd(6'd0, 10'h181, "l3_a0");
    rd(6'd1, 10'h0C2, "l3_a1");
    rd(6'd2, 10'h200, "l3_a2");
    rd(6'd3, 10'h044, "l3_a3_kept");

    // full load without load_last stops at the top address
    for (int i = 0; i < 64; i++) words[i] = 10'(10'h100 + i);
    do_load(64, 1'b0, 1'b0);
    rd(6'd0,  10'h100, "full_a0");
    rd(6'd1,  10'h101, "full_a1");
    rd(6'd5,  10'h105, "full_a5");
    rd(6'd63, 10'h13F, "full_a63");

    // CPU write, same-cycle read sees old data, next read sees new
    bus.MAR   = 6'd5;
    bus.RAMWr = 1'b1;
    bus.MDRIn = 10'h3FF;
    tick();
    bus.RAMWr = 1'b0;
    check("wr_same_cycle_old", bus.MDROut, 10'h105);
    rd(6'd5, 10'h3FF, "wr_readback");
    rd(6'd6, 10'h106, "wr_neighbor");

    // reset after two accepted load words
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 10'h2AB;
    tick();
    bus.load_data  = 10'h2CD;
    tick();
    rst = 1'b1;
    tick();
    check("mrst_load_ready", bus.load_ready, 0);
    check("mrst_cpu_rst", cpu_rst, 1);
    check("mrst_load_done", bus.load_done, 0);
    check("mrst_mdrout", bus.MDROut, 0);
    check("mrst_load_count", bus.load_count, 0);
    bus.load_valid = 1'b0;
    rst = 1'b0;
    clear_wait("mrst_clr");
    for (int a = 0; a < 64; a++) rd(6'(a), 10'h000, "mrst_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
